// File: rtl/write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : write_buffer
// Description : Posted-write FIFO between cache memory port and external RAM.
//               Acknowledges writes immediately, drains in order, forwards
//               reads that hit queued data.
// Revision    : 1.0 - initial release
// ============================================================================
module write_buffer #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDRESS_WIDTH-1:0] ram_address,
    input  logic                     ram_rd,
    input  logic                     ram_wr,
    input  logic [31:0]              ram_data_wr,
    output logic [31:0]              ram_data_rd,
    output logic                     ram_data_valid,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic                     mem_rd,
    output logic                     mem_wr,
    output logic [31:0]              mem_data_wr,
    input  logic [31:0]              mem_data_rd,
    input  logic                     mem_data_valid,
    output logic                     wb_empty
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam int                 c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(DEPTH);

    typedef enum logic [1:0] {
        F_IDLE   = 2'd0,
        F_RD_MEM = 2'd1,
        F_RESP   = 2'd2
    } front_state_t;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_WR   = 2'd1,
        M_RD   = 2'd2
    } mem_state_t;

    front_state_t             front_q, front_d;
    mem_state_t               mstate_q, mstate_d;
    logic [c_ptr_w-1:0]       head_q, head_d;
    logic [c_ptr_w-1:0]       tail_q, tail_d;
    logic [c_cnt_w-1:0]       count_q, count_d;
    logic [DEPTH-1:0]         valid_q, valid_d;
    logic [ADDRESS_WIDTH-1:0] addr_q [DEPTH];
    logic [ADDRESS_WIDTH-1:0] addr_d [DEPTH];
    logic [31:0]              data_q [DEPTH];
    logic [31:0]              data_d [DEPTH];

    logic [31:0]              ram_data_rd_q, ram_data_rd_d;
    logic                     ram_data_valid_q, ram_data_valid_d;
    logic [ADDRESS_WIDTH-1:0] mem_address_q, mem_address_d;
    logic                     mem_rd_q, mem_rd_d;
    logic                     mem_wr_q, mem_wr_d;
    logic [31:0]              mem_data_wr_q, mem_data_wr_d;

    logic                     w_full;
    logic                     w_hit;
    logic [31:0]              w_hit_data;
    logic                     w_push;
    logic                     w_pop;

    assign w_full = (count_q == c_full);

    // Walk oldest to youngest so the last match found is the youngest one.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[head_q + c_ptr_w'(i)] &&
                (addr_q[head_q + c_ptr_w'(i)][ADDRESS_WIDTH-1:2] ==
                 ram_address[ADDRESS_WIDTH-1:2])) begin
                w_hit      = 1'b1;
                w_hit_data = data_q[head_q + c_ptr_w'(i)];
            end
        end
    end

    always_comb begin
        front_d          = front_q;
        mstate_d         = mstate_q;
        head_d           = head_q;
        tail_d           = tail_q;
        count_d          = count_q;
        valid_d          = valid_q;
        addr_d           = addr_q;
        data_d           = data_q;
        ram_data_rd_d    = ram_data_rd_q;
        ram_data_valid_d = 1'b0;
        mem_address_d    = mem_address_q;
        mem_rd_d         = 1'b0;
        mem_wr_d         = 1'b0;
        mem_data_wr_d    = mem_data_wr_q;
        w_push           = 1'b0;
        w_pop            = 1'b0;

        case (front_q)
            F_IDLE: begin
                if (ram_rd) begin
                    if (w_hit) begin
                        ram_data_rd_d    = w_hit_data;
                        ram_data_valid_d = 1'b1;
                        front_d          = F_RESP;
                    end else begin
                        front_d = F_RD_MEM;
                    end
                end else if (ram_wr && !w_full) begin
                    w_push           = 1'b1;
                    ram_data_valid_d = 1'b1;
                    front_d          = F_RESP;
                end
            end
            F_RD_MEM: begin
                // A drain completion during M_WR must not be taken as read data.
                if ((mstate_q == M_RD) && mem_data_valid) begin
                    ram_data_rd_d    = mem_data_rd;
                    ram_data_valid_d = 1'b1;
                    front_d          = F_RESP;
                end
            end
            F_RESP:  front_d = F_IDLE;
            default: front_d = F_IDLE;
        endcase

        case (mstate_q)
            M_IDLE: begin
                if (front_q == F_RD_MEM) begin
                    mem_rd_d      = 1'b1;
                    mem_address_d = ram_address;
                    mstate_d      = M_RD;
                end else if (count_q != '0) begin
                    mem_wr_d      = 1'b1;
                    mem_address_d = addr_q[head_q];
                    mem_data_wr_d = data_q[head_q];
                    mstate_d      = M_WR;
                end
            end
            M_WR: begin
                if (mem_data_valid) begin
                    w_pop    = 1'b1;
                    mstate_d = M_IDLE;
                end
            end
            M_RD: begin
                if (mem_data_valid) begin
                    mstate_d = M_IDLE;
                end
            end
            default: mstate_d = M_IDLE;
        endcase

        if (w_push) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = ram_address;
            data_d[tail_q]  = ram_data_wr;
            tail_d          = tail_q + c_ptr_w'(1);
        end
        if (w_pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + c_ptr_w'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_cnt_w'(1);
            2'b01:   count_d = count_q - c_cnt_w'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front_q          <= F_IDLE;
            mstate_q         <= M_IDLE;
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            valid_q          <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            ram_data_rd_q    <= '0;
            ram_data_valid_q <= 1'b0;
            mem_address_q    <= '0;
            mem_rd_q         <= 1'b0;
            mem_wr_q         <= 1'b0;
            mem_data_wr_q    <= '0;
        end else begin
            front_q          <= front_d;
            mstate_q         <= mstate_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            valid_q          <= valid_d;
            addr_q           <= addr_d;
            data_q           <= data_d;
            ram_data_rd_q    <= ram_data_rd_d;
            ram_data_valid_q <= ram_data_valid_d;
            mem_address_q    <= mem_address_d;
            mem_rd_q         <= mem_rd_d;
            mem_wr_q         <= mem_wr_d;
            mem_data_wr_q    <= mem_data_wr_d;
        end
    end

    assign ram_data_rd    = ram_data_rd_q;
    assign ram_data_valid = ram_data_valid_q;
    assign mem_address    = mem_address_q;
    assign mem_rd         = mem_rd_q;
    assign mem_wr         = mem_wr_q;
    assign mem_data_wr    = mem_data_wr_q;
    // A read in flight leaves no write pending, so it still counts as empty.
    assign wb_empty       = (count_q == '0) && (mstate_q != M_WR);

endmodule
`default_nettype wire

// File: tb/tb_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_write_buffer
// Description : Directed self-checking bench for write_buffer with a
//               variable-latency RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_write_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] ram_address = '0;
    logic        ram_rd = 1'b0;
    logic        ram_wr = 1'b0;
    logic [31:0] ram_data_wr = '0;
    logic [31:0] ram_data_rd;
    logic        ram_data_valid;
    logic [15:0] mem_address;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_data_wr;
    logic [31:0] mem_data_rd = '0;
    logic        mem_data_valid = 1'b0;
    logic        wb_empty;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    write_buffer #(.ADDRESS_WIDTH(16), .DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ram_address   (ram_address),
        .ram_rd        (ram_rd),
        .ram_wr        (ram_wr),
        .ram_data_wr   (ram_data_wr),
        .ram_data_rd   (ram_data_rd),
        .ram_data_valid(ram_data_valid),
        .mem_address   (mem_address),
        .mem_rd        (mem_rd),
        .mem_wr        (mem_wr),
        .mem_data_wr   (mem_data_wr),
        .mem_data_rd   (mem_data_rd),
        .mem_data_valid(mem_data_valid),
        .wb_empty      (wb_empty)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: word i holds {i,i,i,i} until written; lat_cfg cycles to respond.
    int          lat_cfg = 1;
    int          busy_cnt = 0;
    logic [31:0] rd_word = '0;
    logic [31:0] wmem [int];

    function automatic logic [31:0] ram_word(input logic [13:0] w);
        if (wmem.exists(int'(w))) return wmem[int'(w)];
        return {4{w[7:0]}};
    endfunction

    always @(posedge clk) begin
        mem_data_valid <= 1'b0;
        if (busy_cnt > 0) begin
            if (busy_cnt == 1) begin
                mem_data_valid <= 1'b1;
                mem_data_rd    <= rd_word;
            end
            busy_cnt <= busy_cnt - 1;
        end else if (mem_wr) begin
            wmem[int'(mem_address[15:2])] = mem_data_wr;
            busy_cnt <= lat_cfg;
        end else if (mem_rd) begin
            rd_word  <= ram_word(mem_address[15:2]);
            busy_cnt <= lat_cfg;
        end
    end

    logic [15:0] wr_addr_log [$];
    logic [31:0] wr_data_log [$];
    logic [15:0] rd_addr_log [$];
    int          rd_cyc_log  [$];
    int          mdv_cyc_log [$];
    int          wide_pulses = 0;
    logic        prev_wr = 1'b0;
    logic        prev_rd = 1'b0;

    always @(negedge clk) begin
        if (mem_wr) begin
            wr_addr_log.push_back(mem_address);
            wr_data_log.push_back(mem_data_wr);
        end
        if (mem_rd) begin
            rd_addr_log.push_back(mem_address);
            rd_cyc_log.push_back(cyc);
        end
        if (mem_data_valid) mdv_cyc_log.push_back(cyc);
        if ((mem_wr && prev_wr) || (mem_rd && prev_rd)) wide_pulses++;
        prev_wr = mem_wr;
        prev_rd = mem_rd;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Holds a request until acknowledged (bounded), then leaves one idle cycle.
    task automatic do_req(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [31:0] d, output int lat_c,
                          output logic [31:0] rdata, output int ack_cyc);
        ram_rd = rd; ram_wr = wr; ram_address = a; ram_data_wr = d;
        lat_c = -1; rdata = 'x; ack_cyc = -1;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (ram_data_valid) begin
                lat_c   = k;
                rdata   = ram_data_rd;
                ack_cyc = cyc;
                break;
            end
        end
        ram_rd = 1'b0; ram_wr = 1'b0;
        tick();
    endtask

    task automatic wait_empty(input int bound, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            if (wb_empty) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          l, c, wb, rb, mb;
        int          acks [5];
        logic [31:0] r;
        logic        ok;

        tick();
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_ram_data_rd", ram_data_rd, 32'h0);
        chk("rst_ram_data_valid", {31'h0, ram_data_valid}, 32'h0);
        chk("rst_mem_address", {16'h0, mem_address}, 32'h0);
        chk("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
        chk("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
        chk("rst_mem_data_wr", mem_data_wr, 32'h0);
        chk("rst_wb_empty", {31'h0, wb_empty}, 32'h1);
        rst_n = 1'b1;
        tick();

        // Single write drains to RAM.
        wb = wr_addr_log.size();
        do_req(1'b0, 1'b1, 16'hD030, 32'h0000_1234, l, r, c);
        chk("t1_ack_latency", l, 1);
        wait_empty(200, ok);
        chk("t1_empty_reached", {31'h0, ok}, 32'h1);
        chk("t1_num_mem_wr", wr_addr_log.size() - wb, 1);
        chk("t1_mem_address", (wr_addr_log.size() > wb) ? {16'h0, wr_addr_log[wb]} : 32'hx, 32'hD030);
        chk("t1_mem_data_wr", (wr_data_log.size() > wb) ? wr_data_log[wb] : 32'hx, 32'h0000_1234);
        chk("t1_ram_word", ram_word(14'h340C), 32'h0000_1234);

        // Read miss on empty buffer.
        rb = rd_addr_log.size();
        do_req(1'b1, 1'b0, 16'h0020, 32'h0, l, r, c);
        chk("t2_rd_latency", l, 5);
        chk("t2_rd_data", r, 32'h0808_0808);
        chk("t2_num_mem_rd", rd_addr_log.size() - rb, 1);
        chk("t2_rd_address", (rd_addr_log.size() > rb) ? {16'h0, rd_addr_log[rb]} : 32'hx, 32'h0020);

        // Forwarded read, byte offset ignored.
        lat_cfg = 10;
        rb = rd_addr_log.size();
        do_req(1'b0, 1'b1, 16'h0040, 32'hAAAA_5555, l, r, c);
        chk("t3_wr_latency", l, 1);
        do_req(1'b1, 1'b0, 16'h0042, 32'h0, l, r, c);
        chk("t3_fwd_latency", l, 1);
        chk("t3_fwd_data", r, 32'hAAAA_5555);
        chk("t3_no_mem_rd", rd_addr_log.size() - rb, 0);
        wait_empty(200, ok);
        chk("t3_empty_reached", {31'h0, ok}, 32'h1);
        chk("t3_ram_word", ram_word(14'h0010), 32'hAAAA_5555);

        // Fill to DEPTH plus one.
        wb = wr_addr_log.size();
        mb = mdv_cyc_log.size();
        for (int k = 0; k < 5; k++) begin
            do_req(1'b0, 1'b1, 16'h0100 + 16'(4 * k), 32'h5000_0000 + k, l, r, acks[k]);
        end
        chk("t4_ack_spacing_1", acks[1] - acks[0], 2);
        chk("t4_ack_spacing_2", acks[2] - acks[1], 2);
        chk("t4_ack_spacing_3", acks[3] - acks[2], 2);
        chk("t4_fifth_after_drain", (mdv_cyc_log.size() > mb) ? acks[4] - mdv_cyc_log[mb] : -1, 2);
        wait_empty(500, ok);
        chk("t4_empty_reached", {31'h0, ok}, 32'h1);
        chk("t4_num_mem_wr", wr_addr_log.size() - wb, 5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t4_drain_order_%0d", k),
                (wr_addr_log.size() > wb + k) ? {16'h0, wr_addr_log[wb + k]} : 32'hx,
                32'h0100 + 32'(4 * k));
        end

        // Same-address writes: youngest forwards, both drain in order.
        lat_cfg = 3;
        wb = wr_addr_log.size();
        do_req(1'b0, 1'b1, 16'h0200, 32'h1111_1111, l, r, c);
        do_req(1'b0, 1'b1, 16'h0200, 32'h2222_2222, l, r, c);
        do_req(1'b1, 1'b0, 16'h0200, 32'h0, l, r, c);
        chk("t5_youngest_fwd", r, 32'h2222_2222);
        wait_empty(200, ok);
        chk("t5_empty_reached", {31'h0, ok}, 32'h1);
        chk("t5_first_drain", (wr_data_log.size() > wb) ? wr_data_log[wb] : 32'hx, 32'h1111_1111);
        chk("t5_second_drain", (wr_data_log.size() > wb + 1) ? wr_data_log[wb + 1] : 32'hx, 32'h2222_2222);
        chk("t5_ram_word", ram_word(14'h0080), 32'h2222_2222);

        // Read miss while a drain is outstanding.
        lat_cfg = 10;
        mb = mdv_cyc_log.size();
        rb = rd_addr_log.size();
        do_req(1'b0, 1'b1, 16'h0400, 32'h3333_3333, l, r, c);
        do_req(1'b1, 1'b0, 16'h0300, 32'h0, l, r, c);
        chk("t6_rd_data", r, 32'hC0C0_C0C0);
        chk("t6_rd_after_drain",
            ((rd_cyc_log.size() > rb) && (mdv_cyc_log.size() > mb)) ? rd_cyc_log[rb] - mdv_cyc_log[mb] : -1, 2);
        chk("t6_rd_address", (rd_addr_log.size() > rb) ? {16'h0, rd_addr_log[rb]} : 32'hx, 32'h0300);
        wait_empty(200, ok);
        chk("t6_empty_reached", {31'h0, ok}, 32'h1);

        // Reset while a drain is in M_WR.
        for (int k = 0; k < 3; k++) begin
            do_req(1'b0, 1'b1, 16'h0500 + 16'(4 * k), 32'h7000_0000 + k, l, r, c);
        end
        chk("t7_busy_before_reset", {31'h0, wb_empty}, 32'h0);
        chk("t7_mem_address_before", {16'h0, mem_address}, 32'h0500);
        rst_n = 1'b0;
        #1;
        chk("t7_ram_data_rd", ram_data_rd, 32'h0);
        chk("t7_ram_data_valid", {31'h0, ram_data_valid}, 32'h0);
        chk("t7_mem_address", {16'h0, mem_address}, 32'h0);
        chk("t7_mem_wr", {31'h0, mem_wr}, 32'h0);
        chk("t7_mem_rd", {31'h0, mem_rd}, 32'h0);
        chk("t7_mem_data_wr", mem_data_wr, 32'h0);
        chk("t7_wb_empty", {31'h0, wb_empty}, 32'h1);
        repeat (2) tick();
        rst_n = 1'b1;
        wb = wr_addr_log.size();
        repeat (40) tick();
        chk("t7_no_mem_wr_after", wr_addr_log.size() - wb, 0);
        chk("t7_wb_empty_after", {31'h0, wb_empty}, 32'h1);

        chk("single_cycle_pulses", wide_pulses, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/write_buffer.md
Name: write_buffer

Overview:
- Posted-write FIFO between the direct-mapped cache's memory-side port (upstream) and external RAM (downstream).
- Absorbs cache write-backs and write-throughs, acknowledging each in one cycle, then drains them to RAM in order in the background.
- Reads forward from the buffer on an address match; otherwise they bypass queued writes to RAM.

Parameters:
- ADDRESS_WIDTH, 16: byte address width; word index is address[ADDRESS_WIDTH-1:2].
- DEPTH, 4: number of buffered words; must be a power of 2 and at least 2.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- ram_address  input  ADDRESS_WIDTH  upstream request address (from cache)
- ram_rd  input  1  upstream read request
- ram_wr  input  1  upstream write request (full 32-bit word)
- ram_data_wr  input  32  upstream write data
- ram_data_rd  output  32  upstream read data
- ram_data_valid  output  1  one-cycle completion pulse for the upstream read or write
- mem_address  output  ADDRESS_WIDTH  RAM address
- mem_rd  output  1  RAM read pulse
- mem_wr  output  1  RAM write pulse
- mem_data_wr  output  32  RAM write data
- mem_data_rd  input  32  RAM read data
- mem_data_valid  input  1  RAM completion pulse, any latency of 1 cycle or more
- wb_empty  output  1  high when no entries are queued and no drain is in flight

Behaviour:
- Reset: all entries invalid, pointers and count = 0. ram_data_rd = 0, ram_data_valid = 0, mem_address = 0, mem_rd = 0, mem_wr = 0, mem_data_wr = 0, wb_empty = 1.
- Reset mid-operation discards queued and in-flight writes; the RAM response to an aborted op is ignored.
- Upstream handshake:
  - Upstream holds ram_rd/ram_wr, address and data stable until ram_data_valid.
  - The block accepts one request at a time. A request is sampled only in front state F_IDLE; ram_rd takes priority if both are high.
  - ram_data_valid is a single-cycle pulse. A request seen in the pulse cycle is not accepted; it is accepted in the following cycle if still asserted.
- Front FSM: F_IDLE, F_RD_MEM, F_RESP.
  - Write, not full: enqueue address/data at the tail, go to F_RESP; ram_data_valid asserts next cycle.
  - Write, full: stay in F_IDLE and do not acknowledge; accept in the first cycle count < DEPTH.
  - Read, word index matches any valid entry: forward the youngest matching entry's data into ram_data_rd, go to F_RESP (1-cycle latency, no RAM access).
  - Read, no match: go to F_RD_MEM and request a read slot from the memory FSM. When mem_data_valid arrives, latch mem_data_rd into ram_data_rd and go to F_RESP.
  - F_RESP → F_IDLE after one cycle.
- Memory FSM: M_IDLE, M_WR, M_RD. At most one RAM op is outstanding.
  - In M_IDLE, a pending read miss has priority over draining.
  - Read: drive mem_rd = 1 for exactly one cycle with mem_address = ram_address, then M_RD until mem_data_valid.
  - Drain (buffer non-empty): drive mem_wr = 1 for one cycle with the head entry, then M_WR until mem_data_valid. Then pop the head and go to M_IDLE.
  - The head is popped only on mem_data_valid.
  - A read miss arriving during M_WR waits for that drain to finish, then issues before the next drain.
- Simultaneous enqueue and pop in the same cycle: count unchanged, both pointers advance.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. Full when count == DEPTH, empty when count == 0.
- Match compare uses address[ADDRESS_WIDTH-1:2] only; byte offset is ignored.
- No write coalescing: same-address writes occupy separate entries and drain in order.
- wb_empty = (count == 0) and memory FSM in M_IDLE or M_RD.
- mem_data_valid arriving in M_IDLE is ignored.

Test Plan:
- Bench RAM initialised so word i holds {i,i,i,i}; latency is configurable.
- Reset, empty buffer, write 0xD030 / 0x00001234 → ram_data_valid one cycle after acceptance; mem_wr single pulse with mem_address 0xD030, mem_data_wr 0x00001234; wb_empty = 1 after mem_data_valid; RAM word 0x340C = 0x00001234.
- Read 0x0020 from empty buffer → mem_rd single pulse at 0x0020; ram_data_rd = 0x08080808 with ram_data_valid the cycle after mem_data_valid.
- RAM latency 10, write 0x0040 / 0xAAAA5555, then read 0x0042 → forwarded 0xAAAA5555 one cycle after acceptance; no mem_rd issued.
- RAM latency 10, five back-to-back writes 0x0100..0x0110 → first four acknowledged at 2-cycle spacing; fifth not acknowledged until the first drain's mem_data_valid; RAM written in address order.
- Write 0x0200 / 0x11111111 then 0x0200 / 0x22222222, read 0x0200 → 0x22222222; after drain, RAM word holds 0x22222222. Read 0x0300 while a drain is in M_WR → mem_rd issued only after that drain's mem_data_valid; returns 0xC0C0C0C0.
- Queue 3 writes with RAM latency 10, assert rst_n = 0 during M_WR → all outputs return to reset values immediately; wb_empty = 1; no further mem_wr after release.
